xpb_lut_loadable: RTL and testbench

Runtime-loadable, multi-channel reduction lookup table for the modular squaring datapath. It holds the 2^LOOKUP_BITS - 1 nonzero precomputed reduction constants for one digit position; entry 0 is hardwired to zero. The constants are streamed in over a narrow load bus, so a modulus change does not require a rebuild. Once loaded, the block serves CHANNELS independent digit lookups per cycle through a fixed 2-cycle pipeline.

---
 rtl/xpb_lut_loadable.sv | 167 ++++++++++++++++
 tb/tb_xpb_lut_loadable.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/xpb_lut_loadable.sv
// Runtime-loadable reduction-constant table serving CHANNELS parallel digit lookups
// through a fixed two-stage pipeline; constants are streamed in over a narrow bus.
module xpb_lut_loadable #(
  parameter int LOOKUP_BITS = 5,
  parameter int WORD_BITS   = 1024,
  parameter int CHANNELS    = 4,
  parameter int LOAD_BITS   = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            load_start,
  input  logic                            load_valid,
  output logic                            load_ready,
  input  logic [LOAD_BITS-1:0]            load_data,
  output logic                            table_ready,
  input  logic                            lookup_valid,
  input  logic [CHANNELS*LOOKUP_BITS-1:0] lookup_sel,
  output logic                            result_valid,
  output logic [CHANNELS*WORD_BITS-1:0]   result_data,
  output logic                            lookup_error
);

  localparam int BEATS   = WORD_BITS / LOAD_BITS;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ENTRIES = 2 ** LOOKUP_BITS;
  localparam logic [LOOKUP_BITS-1:0] LAST_ENTRY = LOOKUP_BITS'(ENTRIES - 1);
  localparam logic [BEAT_W-1:0]      LAST_BEAT  = BEAT_W'(BEATS - 1);

  generate
    if ((WORD_BITS % LOAD_BITS) != 0) begin : g_bad_load_bits
      $error("xpb_lut_loadable: WORD_BITS must be a multiple of LOAD_BITS");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t                     state_r, state_s;
  logic                       load_ready_r, table_ready_r;
  logic [BEAT_W-1:0]          beat_cnt_r;
  logic [LOOKUP_BITS-1:0]     entry_cnt_r;
  logic [WORD_BITS-1:0]       staging_r;
  logic [WORD_BITS-1:0]       word_s;
  logic [WORD_BITS-1:0]       mem_r [0:ENTRIES-1];
  logic                       beat_accept_s, last_beat_s;
  logic                       accept_s, drop_s;
  logic                       sel_vld_r;
  logic [CHANNELS*LOOKUP_BITS-1:0] sel_r;
  logic [CHANNELS*WORD_BITS-1:0]   read_s;
  logic                       result_valid_r;
  logic [CHANNELS*WORD_BITS-1:0]   result_data_r;
  logic                       lookup_error_r;

  // A load_start in the same cycle wins over any beat offered alongside it.
  assign beat_accept_s = load_valid && load_ready_r && !load_start;
  assign last_beat_s   = beat_accept_s && (beat_cnt_r == LAST_BEAT);
  assign accept_s      = lookup_valid && table_ready_r && !load_start;
  assign drop_s        = lookup_valid && !accept_s;

  // Next-state logic of the load controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (load_start) state_s = ST_LOAD;
        else            state_s = ST_EMPTY;
      end
      ST_LOAD: begin
        if (load_start)                                      state_s = ST_LOAD;
        else if (last_beat_s && (entry_cnt_r == LAST_ENTRY)) state_s = ST_READY;
        else                                                 state_s = ST_LOAD;
      end
      ST_READY: begin
        if (load_start) state_s = ST_LOAD;
        else            state_s = ST_READY;
      end
      default: state_s = ST_EMPTY;
    endcase
  end

  // State register, registered handshake flags and load counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_EMPTY;
      load_ready_r  <= 1'b0;
      table_ready_r <= 1'b0;
      beat_cnt_r    <= {BEAT_W{1'b0}};
      entry_cnt_r   <= {LOOKUP_BITS{1'b0}};
    end else begin
      state_r       <= state_s;
      load_ready_r  <= (state_s == ST_LOAD);
      table_ready_r <= (state_s == ST_READY);
      if (load_start) begin
        beat_cnt_r  <= {BEAT_W{1'b0}};
        entry_cnt_r <= LOOKUP_BITS'(1);
      end else if (last_beat_s) begin
        beat_cnt_r  <= {BEAT_W{1'b0}};
        entry_cnt_r <= entry_cnt_r + LOOKUP_BITS'(1);
      end else if (beat_accept_s) begin
        beat_cnt_r  <= beat_cnt_r + BEAT_W'(1);
      end
    end
  end

  // Merge the incoming beat into its little-endian slot of the staged word.
  always_comb begin
    word_s = staging_r;
    word_s[int'(beat_cnt_r)*LOAD_BITS +: LOAD_BITS] = load_data;
  end

  // Staging and table storage carry no reset; a load must precede any lookup.
  always_ff @(posedge clk) begin
    if (beat_accept_s) begin
      staging_r <= word_s;
    end
    if (last_beat_s) begin
      mem_r[entry_cnt_r] <= word_s;
    end
  end

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_read
      logic [LOOKUP_BITS-1:0] digit_s;
      assign digit_s = sel_r[c*LOOKUP_BITS +: LOOKUP_BITS];
      // Entry 0 is never written, so it is forced to zero here.
      assign read_s[c*WORD_BITS +: WORD_BITS] =
        (digit_s == {LOOKUP_BITS{1'b0}}) ? {WORD_BITS{1'b0}} : mem_r[digit_s];
    end
  endgenerate

  // Two-stage lookup pipeline plus the sticky drop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_vld_r      <= 1'b0;
      sel_r          <= {(CHANNELS*LOOKUP_BITS){1'b0}};
      result_valid_r <= 1'b0;
      result_data_r  <= {(CHANNELS*WORD_BITS){1'b0}};
      lookup_error_r <= 1'b0;
    end else begin
      sel_vld_r      <= accept_s;
      if (accept_s) begin
        sel_r <= lookup_sel;
      end
      result_valid_r <= sel_vld_r;
      if (sel_vld_r) begin
        result_data_r <= read_s;
      end
      // A drop in the load_start cycle must still leave the flag set.
      if (drop_s) begin
        lookup_error_r <= 1'b1;
      end else if (load_start) begin
        lookup_error_r <= 1'b0;
      end
    end
  end

  assign load_ready   = load_ready_r;
  assign table_ready  = table_ready_r;
  assign result_valid = result_valid_r;
  assign result_data  = result_data_r;
  assign lookup_error = lookup_error_r;

endmodule

// File: tb/tb_xpb_lut_loadable.sv
// Directed self-checking bench for xpb_lut_loadable at default parameters.
module tb_xpb_lut_loadable;

  localparam int LB    = 5;
  localparam int WB    = 1024;
  localparam int CH    = 4;
  localparam int LD    = 64;
  localparam int BEATS = WB / LD;
  localparam int NENT  = 2 ** LB;

  logic               clk = 1'b0;
  logic               reset;
  logic               load_start;
  logic               load_valid;
  logic               load_ready;
  logic [LD-1:0]      load_data;
  logic               table_ready;
  logic               lookup_valid;
  logic [CH*LB-1:0]   lookup_sel;
  logic               result_valid;
  logic [CH*WB-1:0]   result_data;
  logic               lookup_error;

  int n_vec = 0;
  int n_bad = 0;

  xpb_lut_loadable #(
    .LOOKUP_BITS(LB), .WORD_BITS(WB), .CHANNELS(CH), .LOAD_BITS(LD)
  ) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .table_ready(table_ready),
    .lookup_valid(lookup_valid), .lookup_sel(lookup_sel),
    .result_valid(result_valid), .result_data(result_data),
    .lookup_error(lookup_error)
  );

  always #5 clk = ~clk;

  // Beat b of entry k carries (tag<<16)|(k<<8)|b; entry 0 is zero.
  function automatic logic [LD-1:0] beat_val(int k, int b, int tag);
    return (64'(tag) << 16) | (64'(k) << 8) | 64'(b);
  endfunction

  function automatic logic [WB-1:0] exp_word(int k, int tag);
    logic [WB-1:0] w;
    w = {WB{1'b0}};
    if (k != 0) begin
      for (int b = 0; b < BEATS; b++) w[b*LD +: LD] = beat_val(k, b, tag);
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one cycle; inputs and checks happen 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel_all(input int d);
    for (int c = 0; c < CH; c++) lookup_sel[c*LB +: LB] = LB'(d);
  endtask

  task automatic do_load(input int tag, input bit gaps, input int stop_k, input int stop_b);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("ld_rdy_on_start", WB'(load_ready), WB'(1));
    chk("tbl_rdy_off_start", WB'(table_ready), WB'(0));
    chk("err_clear_start", WB'(lookup_error), WB'(0));
    for (int k = 1; k < NENT; k++) begin
      for (int b = 0; b < BEATS; b++) begin
        if (gaps) begin
          load_valid = 1'b0;
          repeat ($urandom_range(0, 3)) begin
            load_data = ~beat_val(k, b, tag);
            tick();
            chk("tbl_rdy_gap", WB'(table_ready), WB'(0));
          end
        end
        load_valid = 1'b1;
        load_data  = beat_val(k, b, tag);
        tick();
        if (k == stop_k && b == stop_b) begin
          load_valid = 1'b0;
          return;
        end
        if (!(k == NENT-1 && b == BEATS-1)) begin
          chk("tbl_rdy_early", WB'(table_ready), WB'(0));
        end
      end
    end
    load_valid = 1'b0;
    chk("tbl_rdy_after_load", WB'(table_ready), WB'(1));
    chk("ld_rdy_after_load", WB'(load_ready), WB'(0));
  endtask

  // Digits 0..31 over 8 back-to-back cycles, results checked at +2 cycles.
  task automatic run_lookups(input int tag);
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) begin
        chk("lk_valid", WB'(result_valid), WB'(1));
        for (int c = 0; c < CH; c++)
          chk($sformatf("lk_d%0d", (i-2)*CH + c), result_data[c*WB +: WB],
              exp_word((i-2)*CH + c, tag));
      end else begin
        chk("lk_idle", WB'(result_valid), WB'(0));
      end
      if (i < 8) begin
        lookup_valid = 1'b1;
        for (int c = 0; c < CH; c++) lookup_sel[c*LB +: LB] = LB'(i*CH + c);
      end else begin
        lookup_valid = 1'b0;
      end
      tick();
    end
    chk("lk_valid_drop", WB'(result_valid), WB'(0));
    chk("lk_hold", result_data[3*WB +: WB], exp_word(31, tag));
    chk("lk_no_err", WB'(lookup_error), WB'(0));
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    lookup_valid = 1'b0; lookup_sel = '0;
    repeat (3) tick();
    chk("rst_ld_rdy", WB'(load_ready), WB'(0));
    chk("rst_tbl_rdy", WB'(table_ready), WB'(0));
    chk("rst_rv", WB'(result_valid), WB'(0));
    for (int c = 0; c < CH; c++) chk("rst_data", result_data[c*WB +: WB], WB'(0));
    chk("rst_err", WB'(lookup_error), WB'(0));
    reset = 1'b0;
    lookup_valid = 1'b1;
    set_sel_all(5);
    tick();
    lookup_valid = 1'b0;
    chk("empty_drop_err", WB'(lookup_error), WB'(1));
    for (int i = 0; i < 3; i++) begin
      chk("empty_no_rv", WB'(result_valid), WB'(0));
      tick();
    end

    do_load(1, 1'b0, 0, 0);
    run_lookups(1);

    do_load(2, 1'b1, 0, 0);
    run_lookups(2);

    // Reload overlap: lookups at t-2, t-1, then load_start with a lookup at t.
    lookup_valid = 1'b1; set_sel_all(3);
    tick();
    set_sel_all(9);
    chk("ovl_err_pre", WB'(lookup_error), WB'(0));
    tick();
    load_start = 1'b1; set_sel_all(12);
    chk("ovl_rv_t", WB'(result_valid), WB'(1));
    chk("ovl_old_3", result_data[0 +: WB], exp_word(3, 2));
    tick();
    load_start = 1'b0; lookup_valid = 1'b0;
    chk("ovl_rv_t1", WB'(result_valid), WB'(1));
    chk("ovl_old_9", result_data[2*WB +: WB], exp_word(9, 2));
    chk("ovl_tbl_rdy", WB'(table_ready), WB'(0));
    chk("ovl_ld_rdy", WB'(load_ready), WB'(1));
    chk("ovl_err", WB'(lookup_error), WB'(1));
    tick();
    chk("ovl_rv_t2", WB'(result_valid), WB'(0));

    do_load(3, 1'b0, 10, 7);
    do_load(4, 1'b0, 0, 0);
    run_lookups(4);

    // Reset in the cycle after an accepted lookup.
    lookup_valid = 1'b1; set_sel_all(7);
    tick();
    lookup_valid = 1'b0; reset = 1'b1;
    chk("mrst_rv_t1", WB'(result_valid), WB'(0));
    tick();
    reset = 1'b0;
    chk("mrst_rv_t2", WB'(result_valid), WB'(0));
    for (int c = 0; c < CH; c++) chk("mrst_data", result_data[c*WB +: WB], WB'(0));
    chk("mrst_tbl_rdy", WB'(table_ready), WB'(0));
    chk("mrst_ld_rdy", WB'(load_ready), WB'(0));
    tick();
    chk("mrst_rv_t3", WB'(result_valid), WB'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
